reg_bank_lrid: RTL and testbench

Parametrised bank of NREGS general-purpose registers, each with parallel load, increment, decrement and clear, plus per-register overflow tracking and a wrap/saturate arithmetic mode. It replaces the scattered single load/increment registers in the datapath (address, program-counter and data-style registers) with one block. The block has one load port, one arithmetic-op port and two asynchronous read ports.

---
 rtl/reg_bank_lrid_pkg.sv | 12 +
 rtl/reg_cell_lrid.sv | 77 +++++++
 rtl/reg_bank_lrid.sv | 73 +++++++
 tb/tb_reg_bank_lrid.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_lrid_pkg.sv
// Shared definitions for the reg_bank_lrid register bank: arithmetic-op
// encodings and the op type used on the OP port and inside each cell.
package reg_bank_lrid_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_INC = 2'b00;
    localparam op_t OP_DEC = 2'b01;
    localparam op_t OP_CLR = 2'b10;
    localparam op_t OP_NOP = 2'b11;

endpackage

// File: rtl/reg_cell_lrid.sv
// One register of the bank plus its sticky overflow/underflow flag.
// Priority: RST > load > op > hold. INC at all-ones and DEC at zero set the
// flag; SATURATE chooses between clamping and wrapping in those cases.
module reg_cell_lrid
    import reg_bank_lrid_pkg::*;
#(
    parameter int                 WIDTH     = 16,
    parameter int                 SATURATE  = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             load,
    input  logic             op_en,
    input  op_t              op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             ovf
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             ovf_reg;
    logic             ovf_next;

    // Next-state selection for load and arithmetic ops (reset handled in the flop)
    always_comb begin
        q_next   = q_reg;
        ovf_next = ovf_reg;
        if (load) begin
            q_next   = data;
            ovf_next = 1'b0;
        end else if (op_en) begin
            case (op)
                OP_INC: begin
                    if (q_reg == '1) begin
                        ovf_next = 1'b1;
                        q_next   = (SATURATE != 0) ? q_reg : '0;
                    end else begin
                        q_next = q_reg + WIDTH'(1);
                    end
                end
                OP_DEC: begin
                    if (q_reg == '0) begin
                        ovf_next = 1'b1;
                        q_next   = (SATURATE != 0) ? q_reg : '1;
                    end else begin
                        q_next = q_reg - WIDTH'(1);
                    end
                end
                OP_CLR: begin
                    q_next   = '0;
                    ovf_next = 1'b0;
                end
                default: begin
                    q_next   = q_reg;
                    ovf_next = ovf_reg;
                end
            endcase
        end
    end

    // State register; reset discards any command presented in the same cycle
    always_ff @(posedge clk) begin
        if (RST) begin
            q_reg   <= RESET_VAL;
            ovf_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            ovf_reg <= ovf_next;
        end
    end

    assign q   = q_reg;
    assign ovf = ovf_reg;

endmodule

// File: rtl/reg_bank_lrid.sv
// Bank of NREGS load/inc/dec/clear registers with one load port, one
// arithmetic-op port and two combinational read ports. Address decode and
// read muxes live here; each register is a reg_cell_lrid. The read array is
// padded to a power of two with zero slots so out-of-range reads return 0
// and out-of-range writes/ops decode to no cell.
module reg_bank_lrid
    import reg_bank_lrid_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NREGS     = 4,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] DATA,
    input  logic             OP_EN,
    input  logic [AW-1:0]    OP_ADDR,
    input  op_t              OP,
    input  logic [AW-1:0]    RADDR_A,
    input  logic [AW-1:0]    RADDR_B,
    output logic [WIDTH-1:0] QA,
    output logic [WIDTH-1:0] QB,
    output logic [NREGS-1:0] ZERO,
    output logic [NREGS-1:0] OVF
);

    localparam int NSLOT = 1 << AW;

    logic [WIDTH-1:0] q_all [NSLOT];
    logic [NREGS-1:0] load_vec;
    logic [NREGS-1:0] op_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NREGS) begin : g_cell
                // A load to the same register masks the op, so the load wins
                assign load_vec[gi] = WE && (WADDR == AW'(gi));
                assign op_vec[gi]   = OP_EN && (OP_ADDR == AW'(gi)) && !load_vec[gi];

                reg_cell_lrid #(
                    .WIDTH     (WIDTH),
                    .SATURATE  (SATURATE),
                    .RESET_VAL (RESET_VAL)
                ) u_cell (
                    .clk   (clk),
                    .RST   (RST),
                    .load  (load_vec[gi]),
                    .op_en (op_vec[gi]),
                    .op    (OP),
                    .data  (DATA),
                    .q     (q_all[gi]),
                    .ovf   (OVF[gi])
                );

                assign ZERO[gi] = (q_all[gi] == '0);
            end else begin : g_pad
                assign q_all[gi] = '0;
            end
        end
    endgenerate

    // Read muxes: combinational view of the current register state
    always_comb begin
        QA = q_all[RADDR_A];
        QB = q_all[RADDR_B];
    end

endmodule

// File: tb/tb_reg_bank_lrid.sv
// Directed bench for reg_bank_lrid: one wrap-mode and one saturate-mode
// instance driven with identical stimulus, checked against hand-computed values.
module tb_reg_bank_lrid;
    import reg_bank_lrid_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  waddr;
    logic [15:0] data;
    logic        op_en;
    logic [1:0]  op_addr;
    op_t         op;
    logic [1:0]  raddr_a;
    logic [1:0]  raddr_b;

    logic [15:0] qa_w, qb_w, qa_s, qb_s;
    logic [3:0]  zero_w, ovf_w, zero_s, ovf_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_lrid #(.WIDTH(16), .NREGS(4), .SATURATE(0), .RESET_VAL(16'h0)) u_wrap (
        .clk(clk), .RST(rst), .WE(we), .WADDR(waddr), .DATA(data),
        .OP_EN(op_en), .OP_ADDR(op_addr), .OP(op),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b),
        .QA(qa_w), .QB(qb_w), .ZERO(zero_w), .OVF(ovf_w)
    );

    reg_bank_lrid #(.WIDTH(16), .NREGS(4), .SATURATE(1), .RESET_VAL(16'h0)) u_sat (
        .clk(clk), .RST(rst), .WE(we), .WADDR(waddr), .DATA(data),
        .OP_EN(op_en), .OP_ADDR(op_addr), .OP(op),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b),
        .QA(qa_s), .QB(qb_s), .ZERO(zero_s), .OVF(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; op_en = 1'b0; rst = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] a, input logic [15:0] d);
        idle(); we = 1'b1; waddr = a; data = d;
        step(); idle();
        $display("txn load r%0d=%h", a, d);
    endtask

    task automatic do_op(input logic [1:0] a, input op_t o);
        idle(); op_en = 1'b1; op_addr = a; op = o;
        step(); idle();
        $display("txn op r%0d op=%0d", a, o);
    endtask

    // Read register idx on both ports of both instances
    task automatic rd(input string tag, input logic [1:0] idx,
                      input logic [15:0] exp_w, input logic [15:0] exp_s);
        raddr_a = idx; raddr_b = idx;
        #1;
        chk({tag, "_qa_wrap"}, 32'(qa_w), 32'(exp_w));
        chk({tag, "_qb_wrap"}, 32'(qb_w), 32'(exp_w));
        chk({tag, "_qa_sat"},  32'(qa_s), 32'(exp_s));
        chk({tag, "_qb_sat"},  32'(qb_s), 32'(exp_s));
    endtask

    task automatic flags(input string tag, input logic [3:0] zw, input logic [3:0] ow,
                         input logic [3:0] zs, input logic [3:0] os);
        chk({tag, "_zero_wrap"}, 32'(zero_w), 32'(zw));
        chk({tag, "_ovf_wrap"},  32'(ovf_w),  32'(ow));
        chk({tag, "_zero_sat"},  32'(zero_s), 32'(zs));
        chk({tag, "_ovf_sat"},   32'(ovf_s),  32'(os));
    endtask

    initial begin
        // Reset with a concurrent load and op present: both are discarded
        rst = 1'b1; we = 1'b1; waddr = 2'd0; data = 16'h1234;
        op_en = 1'b1; op_addr = 2'd0; op = OP_INC;
        raddr_a = 2'd0; raddr_b = 2'd0;
        step(); step();
        idle();
        $display("txn reset");
        flags("reset", 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        rd("reset_r0", 2'd0, 16'h0000, 16'h0000);

        // INC at all-ones on r2: wrap -> 0, saturate -> holds; both flag
        do_load(2'd2, 16'hFFFF);
        do_op(2'd2, OP_INC);
        rd("inc_ff_r2", 2'd2, 16'h0000, 16'hFFFF);
        flags("inc_ff", 4'b1111, 4'b0100, 4'b1011, 4'b0100);
        do_load(2'd2, 16'h0005);
        rd("reload_r2", 2'd2, 16'h0005, 16'h0005);
        flags("reload", 4'b1011, 4'b0000, 4'b1011, 4'b0000);

        // DEC at zero on r1, INC at all-ones on r3
        do_op(2'd1, OP_DEC);
        rd("dec0_r1", 2'd1, 16'hFFFF, 16'h0000);
        do_load(2'd3, 16'hFFFF);
        do_op(2'd3, OP_INC);
        rd("inc_ff_r3", 2'd3, 16'h0000, 16'hFFFF);
        flags("ovf13", 4'b1001, 4'b1010, 4'b0011, 4'b1010);

        // NOP leaves everything alone
        do_op(2'd3, OP_NOP);
        rd("nop_r3", 2'd3, 16'h0000, 16'hFFFF);

        // Load wins over op to the same register
        do_load(2'd1, 16'h0009);
        idle(); we = 1'b1; waddr = 2'd0; data = 16'h0007;
        op_en = 1'b1; op_addr = 2'd0; op = OP_INC;
        step(); idle();
        $display("txn load r0=7 + inc r0");
        rd("same_r0", 2'd0, 16'h0007, 16'h0007);

        // Load and op to different registers both take effect
        we = 1'b1; waddr = 2'd0; data = 16'h0007;
        op_en = 1'b1; op_addr = 2'd1; op = OP_INC;
        step(); idle();
        $display("txn load r0=7 + inc r1");
        rd("diff_r0", 2'd0, 16'h0007, 16'h0007);
        rd("diff_r1", 2'd1, 16'h000A, 16'h000A);
        flags("diff", 4'b1000, 4'b1000, 4'b0000, 4'b1000);

        // Read-during-write returns the old value until the edge
        raddr_a = 2'd1; raddr_b = 2'd1;
        we = 1'b1; waddr = 2'd1; data = 16'hAAAA;
        #1;
        chk("rdw_old_qa", 32'(qa_w), 32'h000A);
        chk("rdw_old_qb", 32'(qb_w), 32'h000A);
        step(); idle();
        $display("txn load r1=AAAA with read of r1");
        rd("rdw_new", 2'd1, 16'hAAAA, 16'hAAAA);

        // Sticky OVF across repeated DEC, cleared by CLR
        do_op(2'd0, OP_CLR);
        do_op(2'd0, OP_DEC);
        rd("dec0_r0", 2'd0, 16'hFFFF, 16'h0000);
        flags("dec0", 4'b1000, 4'b1001, 4'b0001, 4'b1001);
        do_op(2'd0, OP_DEC);
        do_op(2'd0, OP_DEC);
        rd("dec2_r0", 2'd0, 16'hFFFD, 16'h0000);
        flags("sticky", 4'b1000, 4'b1001, 4'b0001, 4'b1001);
        do_op(2'd0, OP_CLR);
        rd("clr_r0", 2'd0, 16'h0000, 16'h0000);
        flags("clr", 4'b1001, 4'b1000, 4'b0001, 4'b1000);

        // Mid-operation reset drops the command and restores reset state
        rst = 1'b1; op_en = 1'b1; op_addr = 2'd2; op = OP_INC;
        step(); idle();
        $display("txn reset with inc r2");
        rd("rst2_r2", 2'd2, 16'h0000, 16'h0000);
        flags("rst2", 4'b1111, 4'b0000, 4'b1111, 4'b0000);

        // First command after reset is accepted
        do_op(2'd2, OP_INC);
        rd("post_rst_r2", 2'd2, 16'h0001, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
